l2r_exp_arbiter: RTL

L2R_EXP_ARBITER -- requirements
Module: l2r_exp_arbiter

---
 rtl/l2r_exp_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/l2r_exp_arbiter.sv
// l2r_exp_arbiter: round-robin front end that shares one left-to-right
// exponentiation engine between NREQ requesters. One operation is in flight
// at a time: IDLE picks a winner, ISSUE starts the engine, BUSY waits for
// completion or timeout, RESP holds the result until the consumer takes it.
module l2r_exp_arbiter #(
    parameter int NREQ    = 4,     // 2..8 requesters
    parameter int TIMEOUT = 1023   // 1..65535 BUSY cycles before abort
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   a_in,
    input  logic [16*NREQ-1:0]   b_in,
    output logic [NREQ-1:0]      grant,
    output logic                 rsp_valid,
    output logic [2:0]           rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    input  logic                 rsp_ready,
    output logic                 eng_start,
    output logic [15:0]          eng_a,
    output logic [15:0]          eng_b,
    input  logic [31:0]          eng_c,
    input  logic                 eng_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Pointer reset value makes requester 0 the first candidate after reset.
    localparam logic [2:0]  LAST_INIT = 3'(NREQ - 1);
    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_last_grant;
    logic [2:0]  r_rsp_id;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic [15:0] r_eng_a;
    logic [15:0] r_eng_b;
    logic [15:0] r_cnt;

    logic [15:0] w_a_slice [NREQ];
    logic [15:0] w_b_slice [NREQ];
    logic        w_found_hi;
    logic        w_found_lo;
    logic [2:0]  w_win_hi;
    logic [2:0]  w_win_lo;
    logic        w_found;
    logic [2:0]  w_winner;
    logic [15:0] w_win_a;
    logic [15:0] w_win_b;
    logic        w_cnt_hit;

    // Unpack the flat operand buses into per-requester slices.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign w_a_slice[gi] = a_in[16*gi +: 16];
        assign w_b_slice[gi] = b_in[16*gi +: 16];
    end

    // Round-robin pick: first requester above the last grant, else first one at or below it.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !w_found_hi && (i > int'(r_last_grant))) begin
                w_found_hi = 1'b1;
                w_win_hi   = 3'(i);
            end
            if (req[i] && !w_found_lo && (i <= int'(r_last_grant))) begin
                w_found_lo = 1'b1;
                w_win_lo   = 3'(i);
            end
        end
        w_found  = w_found_hi | w_found_lo;
        w_winner = w_found_hi ? w_win_hi : w_win_lo;
    end

    // Operand mux for the selected winner.
    always_comb begin
        w_win_a = '0;
        w_win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == 3'(i)) begin
                w_win_a = w_a_slice[i];
                w_win_b = w_b_slice[i];
            end
        end
    end

    // The last permitted BUSY cycle: without eng_done here the operation aborts.
    assign w_cnt_hit = (r_cnt == CNT_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; eng_done only matters while BUSY.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_BUSY;
            S_BUSY:  if (eng_done || w_cnt_hit) w_state_next = S_RESP;
            S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs: grant and eng_start coincide in the single ISSUE cycle.
    always_comb begin
        grant     = '0;
        eng_start = (r_state == S_ISSUE);
        rsp_valid = (r_state == S_RESP);
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = (r_state == S_ISSUE) && (r_rsp_id == 3'(i));
        end
    end

    // Datapath: capture winner operands, run the timeout counter, capture the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= LAST_INIT;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_eng_a      <= '0;
            r_eng_b      <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_eng_a      <= w_win_a;
                        r_eng_b      <= w_win_b;
                        r_rsp_id     <= w_winner;
                        r_last_grant <= w_winner;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_BUSY: begin
                    if (eng_done) begin
                        // Completion wins even on the final timeout cycle.
                        r_rsp_data <= eng_c;
                        r_rsp_err  <= 1'b0;
                    end else if (w_cnt_hit) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    // RESP: response registers hold until accepted.
                end
            endcase
        end
    end

    assign rsp_id   = r_rsp_id;
    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;
    assign eng_a    = r_eng_a;
    assign eng_b    = r_eng_b;

endmodule
